// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment patterns for the seven-segment scan display
package seg7_pkg;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000, // 9
    7'b0001000, // A
    7'b0000011, // b
    7'b1000110, // C
    7'b0100001, // d
    7'b0000110, // E
    7'b0001110  // F
  };

  // All segments off (active-low)
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - hex nibble to active-low seven-segment pattern
module seg7_hex_decoder (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);
  import seg7_pkg::*;

  // Pure table lookup
  always_comb begin
    seg_o = SEG_TABLE[nibble_i];
  end

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - multiplexed hex display with PWM dimming, blink and leading-zero blanking
module seg7_scan_display #(
  parameter int NUM_DIGITS   = 8,
  parameter int SUB_DIV      = 6250,
  parameter int BLINK_FRAMES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   en_out,
  output logic [6:0]              out7,
  output logic                    dp_out
);
  import seg7_pkg::*;

  localparam int PW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SUB_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    phase_q, phase_d;
  logic [DW-1:0] digit_q, digit_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_off_q, blink_off_d;

  logic [NUM_DIGITS-1:0][3:0] sh_val_q, sh_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]      sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]      sh_mask_q, sh_mask_d, disp_mask_q, disp_mask_d;

  logic [NUM_DIGITS-1:0] en_out_q, en_out_d;
  logic [6:0]            out7_q, out7_d;
  logic                  dp_out_q, dp_out_d;

  logic       sub_tick, slot_end, frame_end;
  logic       upper_zero, suppress, blinked, lit;
  logic [3:0] cur_nibble;
  logic [6:0] cur_seg;

  // Scan counters, blink phase and shadow/display transfer
  always_comb begin
    sub_tick  = (presc_q == PRESC_LAST);
    slot_end  = sub_tick && (phase_q == 4'hF);
    frame_end = slot_end && (digit_q == DIGIT_LAST);

    presc_d = sub_tick ? '0 : presc_q + PW'(1);
    phase_d = sub_tick ? phase_q + 4'd1 : phase_q;
    digit_d = digit_q;
    if (slot_end) digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + DW'(1);

    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (frame_end) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    // A load on the boundary cycle feeds straight through to the display
    sh_val_d  = load ? value      : sh_val_q;
    sh_dp_d   = load ? dp_in      : sh_dp_q;
    sh_mask_d = load ? blink_mask : sh_mask_q;
    disp_val_d  = frame_end ? sh_val_d  : disp_val_q;
    disp_dp_d   = frame_end ? sh_dp_d   : disp_dp_q;
    disp_mask_d = frame_end ? sh_mask_d : disp_mask_q;
  end

  // Counter and register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      phase_q     <= '0;
      digit_q     <= '0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      sh_val_q    <= '0;
      sh_dp_q     <= '0;
      sh_mask_q   <= '0;
      disp_val_q  <= '0;
      disp_dp_q   <= '0;
      disp_mask_q <= '0;
    end else begin
      presc_q     <= presc_d;
      phase_q     <= phase_d;
      digit_q     <= digit_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      sh_val_q    <= sh_val_d;
      sh_dp_q     <= sh_dp_d;
      sh_mask_q   <= sh_mask_d;
      disp_val_q  <= disp_val_d;
      disp_dp_q   <= disp_dp_d;
      disp_mask_q <= disp_mask_d;
    end
  end

  assign cur_nibble = disp_val_q[digit_q];

  seg7_hex_decoder u_dec (
    .nibble_i (cur_nibble),
    .seg_o    (cur_seg)
  );

  // Decide whether the selected digit is lit and build the next outputs
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(digit_q) && disp_val_q[i] != 4'h0) upper_zero = 1'b0;
    end
    suppress = blank_lz && (digit_q != '0) && upper_zero && !disp_dp_q[digit_q];
    blinked  = blink_off_q && disp_mask_q[digit_q];
    // Phase 0 stays dark so the anode switch never overlaps segment changes
    lit      = (phase_q != 4'h0) && (phase_q <= brightness) && !blinked && !suppress;

    en_out_d = '1;
    out7_d   = SEG_BLANK;
    dp_out_d = 1'b1;
    if (lit) begin
      en_out_d[digit_q] = 1'b0;
      out7_d            = cur_seg;
      dp_out_d          = ~disp_dp_q[digit_q];
    end
  end

  // Registered outputs, forced dark while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_q <= '1;
      out7_q   <= SEG_BLANK;
      dp_out_q <= 1'b1;
    end else begin
      en_out_q <= en_out_d;
      out7_q   <= out7_d;
      dp_out_q <= dp_out_d;
    end
  end

  assign en_out = en_out_q;
  assign out7   = out7_q;
  assign dp_out = dp_out_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - self-checking bench for seg7_scan_display
module tb_seg7_scan_display;
  localparam int N     = 4;
  localparam int SD    = 2;
  localparam int BF    = 2;
  localparam int FRAME = 16 * N * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  brightness = 4'd15;
  logic [3:0]  en_out;
  logic [6:0]  out7;
  logic        dp_out;

  always #5 clk = ~clk;

  seg7_scan_display #(.NUM_DIGITS(N), .SUB_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blink_mask(blink_mask), .blank_lz(blank_lz), .brightness(brightness),
    .en_out(en_out), .out7(out7), .dp_out(dp_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] seg_ref [16];

  // Reference model state: edges since reset release, shadow and shown data
  int          edges_m = 0;
  logic [15:0] sh_v_m = '0, disp_v_m = '0;
  logic [3:0]  sh_dp_m = '0, disp_dp_m = '0, sh_mk_m = '0, disp_mk_m = '0;

  int         en_cnt [4];
  logic [6:0] seg_seen [4];
  logic       dp_seen [4];

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic            blank;
    logic [3:0]      bright;
    logic [3:0][7:0] cnt;
    logic [3:0][6:0] seg;
    logic [3:0]      dpo;
  } vec_t;

  vec_t vt [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    edges_m = 0;
    sh_v_m = '0; disp_v_m = '0;
    sh_dp_m = '0; disp_dp_m = '0;
    sh_mk_m = '0; disp_mk_m = '0;
  endtask

  // One clock: predict the outputs from time-since-reset, advance the model, compare
  task automatic tick();
    int t, s, ph, dg;
    bit boff, zero_above, lit;
    logic [3:0] nib, exp_en;
    logic [6:0] exp_seg;
    logic exp_dp;
    @(posedge clk);
    t  = edges_m;
    s  = t / SD;
    ph = s % 16;
    dg = (s / 16) % N;
    boff = ((t / FRAME) / BF) % 2 == 1;
    zero_above = (disp_v_m >> (4 * dg)) == 16'h0;
    nib = disp_v_m[4*dg +: 4];
    lit = (ph >= 1) && (ph <= int'(brightness)) && !(boff && disp_mk_m[dg])
          && !(blank_lz && dg != 0 && zero_above && !disp_dp_m[dg]);
    exp_en  = lit ? ~(4'b0001 << dg) : 4'hF;
    exp_seg = lit ? seg_ref[nib] : 7'h7F;
    exp_dp  = lit ? ~disp_dp_m[dg] : 1'b1;
    edges_m++;
    if (load) begin
      sh_v_m = value; sh_dp_m = dp_in; sh_mk_m = blink_mask;
    end
    if (edges_m % FRAME == 0) begin
      disp_v_m = sh_v_m; disp_dp_m = sh_dp_m; disp_mk_m = sh_mk_m;
    end
    @(negedge clk);
    check("cycle", {en_out, out7, dp_out}, {exp_en, exp_seg, exp_dp});
    for (int d = 0; d < N; d++) begin
      if (!en_out[d]) begin
        en_cnt[d]++;
        seg_seen[d] = out7;
        dp_seen[d]  = dp_out;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic to_boundary();
    int guard;
    guard = 0;
    while (edges_m % FRAME != 0 && guard < FRAME) begin
      tick();
      guard++;
    end
  endtask

  task automatic clear_counts();
    for (int d = 0; d < N; d++) begin
      en_cnt[d] = 0; seg_seen[d] = 7'h7F; dp_seen[d] = 1'b1;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] mk);
    value = v; dp_in = dp; blink_mask = mk; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int first, f;
    logic [3:0] first_en;
    logic [15:0] rv;
    int keep, r;

    seg_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // value, dp, blank, bright, per-digit counts {d3..d0}, segments {d3..d0}, dp_out {d3..d0}
    vt[0] = '{16'h12A8, 4'h0, 1'b0, 4'd15, {8'd30, 8'd30, 8'd30, 8'd30},
              {7'b1111001, 7'b0100100, 7'b0001000, 7'b0000000}, 4'b1111};
    vt[1] = '{16'h0005, 4'b0100, 1'b1, 4'd15, {8'd0, 8'd30, 8'd0, 8'd30},
              {7'b1111111, 7'b1000000, 7'b1111111, 7'b0010010}, 4'b1011};
    vt[2] = '{16'h12A8, 4'h0, 1'b0, 4'd0, {8'd0, 8'd0, 8'd0, 8'd0},
              {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111}, 4'b1111};
    vt[3] = '{16'h3C7E, 4'b1010, 1'b0, 4'd3, {8'd6, 8'd6, 8'd6, 8'd6},
              {7'b0110000, 7'b1000110, 7'b1111000, 7'b0000110}, 4'b0101};
    vt[4] = '{16'h0000, 4'h0, 1'b1, 4'd15, {8'd0, 8'd0, 8'd0, 8'd30},
              {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
    vt[5] = '{16'h0F00, 4'h0, 1'b1, 4'd8, {8'd0, 8'd16, 8'd16, 8'd16},
              {7'b1111111, 7'b0001110, 7'b1000000, 7'b1000000}, 4'b1111};
    vt[6] = '{16'h3469, 4'h0, 1'b0, 4'd15, {8'd30, 8'd30, 8'd30, 8'd30},
              {7'b0110000, 7'b0011001, 7'b0000010, 7'b0010000}, 4'b1111};
    vt[7] = '{16'hBD57, 4'h0, 1'b0, 4'd15, {8'd30, 8'd30, 8'd30, 8'd30},
              {7'b0000011, 7'b0100001, 7'b0010010, 7'b1111000}, 4'b1111};
    vt[8] = '{16'hFEC0, 4'h0, 1'b0, 4'd15, {8'd30, 8'd30, 8'd30, 8'd30},
              {7'b0001110, 7'b0000110, 7'b1000110, 7'b1000000}, 4'b1111};

    // Outputs dark while held in reset
    #23;
    check("reset_en", en_out, 4'hF);
    check("reset_out7", out7, 7'h7F);
    check("reset_dp", dp_out, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(40);

    // Reset mid-scan with a pending load: outputs go dark at once, shadow discarded
    do_load(16'h9999, 4'hF, 4'h0);
    run(10);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_en", en_out, 4'hF);
    check("midreset_out7", out7, 7'h7F);
    check("midreset_dp", dp_out, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    first = 0;
    first_en = 4'hF;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (first == 0 && en_out != 4'hF) begin
        first = k; first_en = en_out;
      end
    end
    check("first_enable_edge", first, 3);
    check("first_enable_digit", first_en, 4'b1110);
    to_boundary();
    clear_counts();
    run(FRAME);
    check("after_reset_digit3_zero", seg_seen[3], 7'b1000000);

    // Table vectors: one full frame after the load lands
    for (int i = 0; i < 9; i++) begin
      blank_lz   = vt[i].blank;
      brightness = vt[i].bright;
      do_load(vt[i].value, vt[i].dp, 4'h0);
      to_boundary();
      clear_counts();
      run(FRAME);
      for (int d = 0; d < N; d++) begin
        check($sformatf("vec%0d_cnt_d%0d", i, d), en_cnt[d], 32'(vt[i].cnt[d]));
        if (vt[i].cnt[d] != 0) begin
          check($sformatf("vec%0d_seg_d%0d", i, d), seg_seen[d], vt[i].seg[d]);
          check($sformatf("vec%0d_dp_d%0d", i, d), dp_seen[d], vt[i].dpo[d]);
        end
      end
    end

    // Blink: digit 0 alternates two dark frames and two lit frames
    blank_lz = 1'b0;
    brightness = 4'd15;
    do_load(16'h4321, 4'h0, 4'b0001);
    to_boundary();
    for (int fr = 0; fr < 6; fr++) begin
      f = edges_m / FRAME;
      clear_counts();
      run(FRAME);
      check($sformatf("blink_f%0d_d0", fr), en_cnt[0], ((f / BF) % 2 == 1) ? 0 : 30);
      check($sformatf("blink_f%0d_d1", fr), en_cnt[1], 30);
    end

    // Two loads inside one frame: current frame unchanged, last load shown next
    do_load(16'h5555, 4'h0, 4'h0);
    to_boundary();
    clear_counts();
    run(20);
    do_load(16'h1111, 4'h0, 4'h0);
    run(10);
    do_load(16'h2222, 4'h0, 4'h0);
    run(FRAME - 32);
    check("twoload_cur_d0", seg_seen[0], seg_ref[5]);
    check("twoload_cur_d3", seg_seen[3], seg_ref[5]);
    clear_counts();
    run(FRAME);
    check("twoload_next_d0", seg_seen[0], seg_ref[2]);
    check("twoload_next_d3", seg_seen[3], seg_ref[2]);
    check("twoload_next_cnt", en_cnt[2], 30);

    // Load on the boundary cycle itself is shown in the frame that follows
    run(FRAME - 1);
    do_load(16'h7777, 4'h0, 4'h0);
    clear_counts();
    run(FRAME);
    check("boundary_load_d0", seg_seen[0], seg_ref[7]);
    check("boundary_load_d2", seg_seen[2], seg_ref[7]);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        rv = 16'($urandom);
        keep = int'($urandom_range(0, 4));
        rv = (keep == 0) ? 16'h0 : (rv & (16'hFFFF >> (4 * (4 - keep))));
        value = rv;
        dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        blink_mask = 4'($urandom);
        load = 1'b1;
      end
      if (r == 50) brightness = 4'($urandom);
      if (r == 51) blank_lz = ~blank_lz;
      tick();
      load = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
